// File: rtl/link_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : link_frame_ctrl
// Purpose  : Half-duplex framed-link controller for the SWIPT coil link.
//            Serialises one command frame (preamble, mode, type, payload,
//            parity, trailer) onto dout, waits a blind interval, then opens a
//            listen window for the answer decoder. Bounded retransmission on
//            timeout or bad answer checksum; result reported on resp_*.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1        clock
//   nrst        in   1        synchronous active-low reset
//   enable      in   1        link allowed; low acts as synchronous abort
//   tx_valid    in   1        frame request valid
//   tx_ready    out  1        controller can accept a frame (IDLE only)
//   tx_mode     in   2        mode field
//   tx_type     in   2        type field
//   tx_data     in   DATA_W   payload
//   rx_valid    in   1        decoder answer complete (1-cycle pulse)
//   rx_data     in   RX_W     decoded answer
//   rx_chk_ok   in   1        decoder checksum good, qualified by rx_valid
//   dout        out  1        serial line to coil driver
//   write       out  1        high while transmitting
//   read        out  1        high in blind and listen phases
//   rx_en       out  1        answer decoder enable (listen phase only)
//   resp_valid  out  1        1-cycle pulse: transaction finished
//   resp_data   out  RX_W     last good answer
//   resp_err    out  1        with resp_valid: all attempts failed
//   retry_cnt   out  RETRY_W  retransmissions used in current/last transaction
// ============================================================================
module link_frame_ctrl #(
   parameter int              DATA_W       = 16,
   parameter int              RX_W         = 8,
   parameter int              PRE_W        = 6,
   parameter logic [PRE_W-1:0] PREAMBLE    = 6'b101010,
   parameter int              BIT_CYCLES   = 200000,
   parameter int              BLIND_CYCLES = 1000000,
   parameter int              RESP_CYCLES  = 10000000,
   parameter int              MAX_RETRY    = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              enable,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        tx_mode,
   input  logic [1:0]        tx_type,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              rx_valid,
   input  logic [RX_W-1:0]   rx_data,
   input  logic              rx_chk_ok,
   output logic              dout,
   output logic              write,
   output logic              read,
   output logic              rx_en,
   output logic              resp_valid,
   output logic [RX_W-1:0]   resp_data,
   output logic              resp_err,
   output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1)-1:0] retry_cnt
);

   // -------------------------------------------------------------------------
   // Derived sizes and terminal counts
   // -------------------------------------------------------------------------
   localparam int FRAME_W   = PRE_W + 4 + DATA_W + 5;
   localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int BIT_IDX_W = $clog2(FRAME_W);
   localparam int CYC_W     = $clog2(BIT_CYCLES);
   localparam int TMR_W     = $clog2(RESP_CYCLES);

   localparam logic [BIT_IDX_W-1:0] BIT_LAST   = BIT_IDX_W'(FRAME_W - 1);
   localparam logic [CYC_W-1:0]     CYC_LAST   = CYC_W'(BIT_CYCLES - 1);
   localparam logic [TMR_W-1:0]     BLIND_LAST = TMR_W'(BLIND_CYCLES - 1);
   localparam logic [TMR_W-1:0]     TMR_LAST   = TMR_W'(RESP_CYCLES - 1);
   localparam logic [RETRY_W-1:0]   RETRY_MAX  = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEND   = 3'd1,
      S_BLIND  = 3'd2,
      S_LISTEN = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t               state;
   logic [FRAME_W-1:0]   frame_reg;   // latched frame, reused for retransmits
   logic [FRAME_W-2:0]   shift_reg;   // bits still to send after the one on dout
   logic [BIT_IDX_W-1:0] bit_idx;
   logic [CYC_W-1:0]     cyc_cnt;
   logic [TMR_W-1:0]     tmr;         // runs from blind entry to response timeout

   // Frame assembled straight from the request fields; parity is even over
   // the payload so an even number of ones gives a 0 parity bit.
   logic [FRAME_W-1:0] new_frame;
   assign new_frame = {PREAMBLE, tx_mode, tx_type, tx_data, ^tx_data, 4'b0101};

   // A received answer takes precedence over a timeout in the same cycle;
   // a bad checksum counts as a failed attempt just like silence.
   logic listen_fail;
   assign listen_fail = rx_valid ? !rx_chk_ok : (tmr == TMR_LAST);

   // -------------------------------------------------------------------------
   // Controller FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nrst || !enable) begin
         // Reset and abort share one path: drop any transaction silently.
         state      <= S_IDLE;
         frame_reg  <= '0;
         shift_reg  <= '0;
         bit_idx    <= '0;
         cyc_cnt    <= '0;
         tmr        <= '0;
         tx_ready   <= 1'b0;
         dout       <= 1'b0;
         write      <= 1'b0;
         read       <= 1'b0;
         rx_en      <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         retry_cnt  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               tx_ready <= 1'b1;
               if (tx_valid && tx_ready) begin
                  frame_reg <= new_frame;
                  shift_reg <= new_frame[FRAME_W-2:0];
                  dout      <= new_frame[FRAME_W-1];
                  bit_idx   <= '0;
                  cyc_cnt   <= '0;
                  retry_cnt <= '0;
                  write     <= 1'b1;
                  tx_ready  <= 1'b0;
                  state     <= S_SEND;
               end
            end

            S_SEND: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  if (bit_idx == BIT_LAST) begin
                     dout  <= 1'b0;
                     write <= 1'b0;
                     read  <= 1'b1;
                     tmr   <= '0;
                     state <= S_BLIND;
                  end else begin
                     bit_idx   <= bit_idx + BIT_IDX_W'(1);
                     dout      <= shift_reg[FRAME_W-2];
                     shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end

            S_BLIND: begin
               // Answers arriving here are line echo from our own burst.
               tmr <= tmr + TMR_W'(1);
               if (tmr == BLIND_LAST) begin
                  rx_en <= 1'b1;
                  state <= S_LISTEN;
               end
            end

            S_LISTEN: begin
               if (rx_valid && rx_chk_ok) begin
                  resp_data  <= rx_data;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  read       <= 1'b0;
                  rx_en      <= 1'b0;
                  state      <= S_DONE;
               end else if (listen_fail) begin
                  read  <= 1'b0;
                  rx_en <= 1'b0;
                  if (retry_cnt < RETRY_MAX) begin
                     retry_cnt <= retry_cnt + RETRY_W'(1);
                     shift_reg <= frame_reg[FRAME_W-2:0];
                     dout      <= frame_reg[FRAME_W-1];
                     bit_idx   <= '0;
                     cyc_cnt   <= '0;
                     write     <= 1'b1;
                     state     <= S_SEND;
                  end else begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= S_DONE;
                  end
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end

            S_DONE: begin
               resp_err <= 1'b0;
               tx_ready <= 1'b1;
               state    <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_link_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_frame_ctrl
// Purpose  : Directed self-checking bench for link_frame_ctrl with small
//            timing parameters (4-cycle bits, 10-cycle blind, 40-cycle
//            response window, one retry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_frame_ctrl;

   localparam int DATA_W       = 8;
   localparam int RX_W         = 8;
   localparam int PRE_W        = 6;
   localparam int BIT_CYCLES   = 4;
   localparam int BLIND_CYCLES = 10;
   localparam int RESP_CYCLES  = 40;
   localparam int MAX_RETRY    = 1;
   localparam int F            = 23;
   localparam int FRAME_CYC    = F * BIT_CYCLES;
   localparam int LISTEN_CYC   = RESP_CYCLES - BLIND_CYCLES;

   // Hand-assembled frames: preamble_mode_type_data_parity_trailer
   localparam logic [F-1:0] FR_A5 = 23'b101010_10_01_10100101_0_0101; // 2,1,A5
   localparam logic [F-1:0] FR_07 = 23'b101010_01_11_00000111_1_0101; // 1,3,07
   localparam logic [F-1:0] FR_00 = 23'b101010_00_00_00000000_0_0101; // 0,0,00

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              enable = 1'b1;
   logic              tx_valid = 1'b0;
   logic              tx_ready;
   logic [1:0]        tx_mode = 2'd0;
   logic [1:0]        tx_type = 2'd0;
   logic [DATA_W-1:0] tx_data = '0;
   logic              rx_valid = 1'b0;
   logic [RX_W-1:0]   rx_data = '0;
   logic              rx_chk_ok = 1'b0;
   logic              dout, write, read, rx_en, resp_valid, resp_err;
   logic [RX_W-1:0]   resp_data;
   logic              retry_cnt;

   int errors = 0;
   int checks = 0;

   link_frame_ctrl #(
      .DATA_W(DATA_W), .RX_W(RX_W), .PRE_W(PRE_W), .PREAMBLE(6'b101010),
      .BIT_CYCLES(BIT_CYCLES), .BLIND_CYCLES(BLIND_CYCLES),
      .RESP_CYCLES(RESP_CYCLES), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .nrst(nrst), .enable(enable),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_mode(tx_mode), .tx_type(tx_type), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_chk_ok(rx_chk_ok),
      .dout(dout), .write(write), .read(read), .rx_en(rx_en),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic tick;
      @(negedge clk);
   endtask

   // Present a request for one edge; controller must be ready.
   task automatic request(input logic [1:0] m, input logic [1:0] t, input logic [7:0] d);
      tx_mode = m; tx_type = t; tx_data = d; tx_valid = 1'b1;
      checks++;
      if (tx_ready !== 1'b1) begin
         errors++; $display("FAIL req_ready: tx_ready=%b want 1", tx_ready);
      end
      tick;
      tx_valid = 1'b0;
   endtask

   task automatic send_phase(input logic [F-1:0] frame, input int ncyc, input logic exp_retry, input string tag);
      logic exp_bit;
      checks++;
      if (retry_cnt !== exp_retry) begin
         errors++; $display("FAIL %s retry_cnt: got %b want %b", tag, retry_cnt, exp_retry);
      end
      for (int i = 0; i < ncyc; i++) begin
         exp_bit = frame[F-1-(i/BIT_CYCLES)];
         checks++;
         if (dout !== exp_bit) begin
            errors++; $display("FAIL %s dout cyc%0d: got %b want %b", tag, i, dout, exp_bit);
         end
         checks++;
         if ({write, read, rx_en, tx_ready, resp_valid} !== 5'b10000) begin
            errors++; $display("FAIL %s send_ctl cyc%0d: w/r/en/rdy/rv=%b want 10000", tag, i,
                               {write, read, rx_en, tx_ready, resp_valid});
         end
         tick;
      end
   endtask

   task automatic blind_phase(input int rx_at, input string tag);
      for (int j = 0; j < BLIND_CYCLES; j++) begin
         checks++;
         if ({write, read, rx_en, dout, resp_valid, tx_ready} !== 6'b010000) begin
            errors++; $display("FAIL %s blind cyc%0d: w/r/en/d/rv/rdy=%b want 010000", tag, j,
                               {write, read, rx_en, dout, resp_valid, tx_ready});
         end
         rx_valid  = (j == rx_at);
         rx_chk_ok = 1'b1;
         rx_data   = 8'h99;
         tick;
      end
      rx_valid = 1'b0;
   endtask

   task automatic listen_phase(input int n, input string tag);
      for (int j = 0; j < n; j++) begin
         checks++;
         if ({write, read, rx_en, dout, resp_valid, tx_ready} !== 6'b011000) begin
            errors++; $display("FAIL %s listen cyc%0d: w/r/en/d/rv/rdy=%b want 011000", tag, j,
                               {write, read, rx_en, dout, resp_valid, tx_ready});
         end
         tick;
      end
   endtask

   task automatic done_phase(input logic exp_err, input logic [7:0] exp_data, input logic exp_retry, input string tag);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== exp_err) begin
         errors++; $display("FAIL %s done_resp: rv=%b err=%b want 1 %b", tag, resp_valid, resp_err, exp_err);
      end
      checks++;
      if (resp_data !== exp_data) begin
         errors++; $display("FAIL %s done_data: got %h want %h", tag, resp_data, exp_data);
      end
      checks++;
      if (retry_cnt !== exp_retry) begin
         errors++; $display("FAIL %s done_retry: got %b want %b", tag, retry_cnt, exp_retry);
      end
      checks++;
      if ({write, read, rx_en, tx_ready, dout} !== 5'b00000) begin
         errors++; $display("FAIL %s done_ctl: w/r/en/rdy/d=%b want 00000", tag, {write, read, rx_en, tx_ready, dout});
      end
      tick;
      checks++;
      if (resp_valid !== 1'b0 || tx_ready !== 1'b1 || resp_data !== exp_data) begin
         errors++; $display("FAIL %s after_done: rv=%b rdy=%b data=%h want 0 1 %h", tag,
                            resp_valid, tx_ready, resp_data, exp_data);
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0; enable = 1'b1;
      tick; tick;
      checks++;
      if ({tx_ready, dout, write, read, rx_en, resp_valid, resp_err, retry_cnt} !== 8'b0 || resp_data !== 8'h00) begin
         errors++; $display("FAIL reset_outputs: ctl=%b data=%h want all 0",
                            {tx_ready, dout, write, read, rx_en, resp_valid, resp_err, retry_cnt}, resp_data);
      end
      nrst = 1'b1;
      tick;
      checks++;
      if (tx_ready !== 1'b1 || write !== 1'b0) begin
         errors++; $display("FAIL reset_release: tx_ready=%b write=%b want 1 0", tx_ready, write);
      end
   endtask

   task automatic test_ok_answer;
      request(2'd2, 2'd1, 8'hA5);
      send_phase(FR_A5, FRAME_CYC, 1'b0, "ok");
      blind_phase(-1, "ok");
      listen_phase(2, "ok");
      rx_valid = 1'b1; rx_chk_ok = 1'b1; rx_data = 8'h3C;
      tick;
      rx_valid = 1'b0;
      done_phase(1'b0, 8'h3C, 1'b0, "ok");
   endtask

   task automatic test_abort;
      request(2'd2, 2'd1, 8'hA5);
      send_phase(FR_A5, 5 * BIT_CYCLES, 1'b0, "abort");
      enable = 1'b0;
      tick;
      checks++;
      if ({tx_ready, dout, write, read, rx_en, resp_valid, resp_err, retry_cnt} !== 8'b0 || resp_data !== 8'h00) begin
         errors++; $display("FAIL abort_outputs: ctl=%b data=%h want all 0",
                            {tx_ready, dout, write, read, rx_en, resp_valid, resp_err, retry_cnt}, resp_data);
      end
      tick;
      enable = 1'b1;
      tick;
      checks++;
      if (tx_ready !== 1'b1 || resp_valid !== 1'b0 || write !== 1'b0) begin
         errors++; $display("FAIL abort_recover: rdy=%b rv=%b w=%b want 1 0 0", tx_ready, resp_valid, write);
      end
   endtask

   task automatic test_timeout_retry;
      request(2'd2, 2'd1, 8'hA5);
      send_phase(FR_A5, FRAME_CYC, 1'b0, "to1");
      blind_phase(-1, "to1");
      listen_phase(LISTEN_CYC, "to1");
      send_phase(FR_A5, FRAME_CYC, 1'b1, "to2");
      blind_phase(-1, "to2");
      listen_phase(LISTEN_CYC, "to2");
      done_phase(1'b1, 8'h00, 1'b1, "to");
   endtask

   task automatic test_bad_chk_and_blind;
      request(2'd1, 2'd3, 8'h07);
      // Competing request during SEND must neither be taken nor alter the frame.
      tx_valid = 1'b1; tx_mode = 2'd3; tx_type = 2'd0; tx_data = 8'hFF;
      send_phase(FR_07, FRAME_CYC, 1'b0, "bad1");
      blind_phase(3, "bad1");
      listen_phase(5, "bad1");
      tx_valid = 1'b0;
      rx_valid = 1'b1; rx_chk_ok = 1'b0; rx_data = 8'h77;
      tick;
      rx_valid = 1'b0;
      send_phase(FR_07, FRAME_CYC, 1'b1, "bad2");
      blind_phase(-1, "bad2");
      listen_phase(1, "bad2");
      rx_valid = 1'b1; rx_chk_ok = 1'b1; rx_data = 8'h5A;
      tick;
      rx_valid = 1'b0;
      done_phase(1'b0, 8'h5A, 1'b1, "bad");
   endtask

   task automatic test_reset_in_listen;
      request(2'd0, 2'd0, 8'h00);
      send_phase(FR_00, FRAME_CYC, 1'b0, "rl1");
      blind_phase(-1, "rl1");
      listen_phase(LISTEN_CYC, "rl1");
      send_phase(FR_00, FRAME_CYC, 1'b1, "rl2");
      blind_phase(-1, "rl2");
      listen_phase(3, "rl2");
      nrst = 1'b0;
      tick;
      checks++;
      if ({tx_ready, dout, write, read, rx_en, resp_valid, resp_err, retry_cnt} !== 8'b0 || resp_data !== 8'h00) begin
         errors++; $display("FAIL listen_reset: ctl=%b data=%h want all 0",
                            {tx_ready, dout, write, read, rx_en, resp_valid, resp_err, retry_cnt}, resp_data);
      end
      nrst = 1'b1;
      tick;
      checks++;
      if (tx_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL listen_reset_release: rdy=%b rv=%b want 1 0", tx_ready, resp_valid);
      end
   endtask

   initial begin
      test_reset;
      test_ok_answer;
      test_abort;
      test_timeout_retry;
      test_bad_chk_and_blind;
      test_reset_in_listen;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
